ymp_alu_matrix_stream_sched: RTL and testbench
==============================================

Name: ymp_alu_matrix_stream_sched

Overview:
Packet-granular round-robin scheduler that shares one ALU matrix AXI-Stream input between N_REQ requester streams. It returns each result packet to the requester that issued the job. It sits between the requester stream sources/sinks and the matrix AXI-Stream input/output ports. An in-order ID FIFO tracks outstanding jobs, because the matrix emits exactly one result packet per input packet, in order.

Parameters:
AXI_DATA_W, 32, stream data width (matches the matrix).
N_REQ, 2, number of requesters, 2..4.
MAX_OUTSTANDING, 4, ID FIFO depth, power of 2, >=2.

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
req_data_i  in  N_REQ*AXI_DATA_W  requester job data, requester k at slice k
req_valid_i  in  N_REQ  job beat valid
req_last_i  in  N_REQ  last beat of job packet
req_ready_o  out  N_REQ  job beat accepted
mtx_data_o  out  AXI_DATA_W  to matrix input
mtx_valid_o  out  1  to matrix input
mtx_last_o  out  1  to matrix input
mtx_ready_i  in  1  from matrix input
res_data_i  in  AXI_DATA_W  matrix result data
res_valid_i  in  1  matrix result valid
res_last_i  in  1  matrix result last
res_ready_o  out  1  to matrix output
rsp_data_o  out  N_REQ*AXI_DATA_W  result to requesters (all slices carry res_data_i)
rsp_valid_o  out  N_REQ  result valid, one-hot or zero
rsp_last_o  out  N_REQ  result last, qualified per requester
rsp_ready_i  in  N_REQ  requester result ready
busy_o  out  1  high in GRANT or when the ID FIFO is not empty
outstanding_o  out  $clog2(MAX_OUTSTANDING)+1  ID FIFO occupancy

Behaviour:
- Reset (async, active-high): FSM=IDLE, rr pointer=0, FIFO empty, count=0. All valid and ready outputs are 0 and stay 0 while rst_i is high. Any in-flight packet is abandoned; no recovery.
- FSM IDLE:
  - When any req_valid_i is set and the FIFO is not full, register grant g, push g into the FIFO, and go to GRANT.
  - g is the first set req_valid_i at or after rr pointer, searching upward with wrap.
  - req_ready_o=0 and mtx_valid_o=0 in IDLE.
- FSM GRANT (combinational pass-through, zero latency):
  - mtx_data_o/valid/last follow requester g.
  - req_ready_o[g]=mtx_ready_i; all other req_ready_o=0.
  - A handshake with last=1 returns the FSM to IDLE and sets rr pointer=(g+1) mod N_REQ.
  - Non-g requesters are never granted mid-packet. Exactly one idle cycle separates consecutive packets.
- Full FIFO: no grant. A pop in the same cycle does not enable a grant that cycle; the grant takes effect the next cycle.
- Result return:
  - h = FIFO head.
  - When the FIFO is not empty: rsp_valid_o[h]=res_valid_i, rsp_last_o[h]=res_last_i, res_ready_o=rsp_ready_i[h].
  - When the FIFO is empty: res_ready_o=0 and rsp_valid_o=0.
  - Pop on res_valid_i & res_ready_o & res_last_i.
- Simultaneous push and pop: count unchanged, both pointers advance. The count never exceeds MAX_OUTSTANDING.
- A push in cycle t makes that entry visible as head in cycle t+1.
- A single-beat packet (valid and last in the first GRANT cycle) is legal: one GRANT cycle, then IDLE.
- outstanding_o is the registered count. busy_o is combinational from FSM state and count.

Test Plan:
- Req0 and req1 both hold 3-beat packets continuously, matrix always ready -> grants alternate 0,1,0,1. One idle cycle between packets. mtx beats are exactly the requester data in order.
- Only req1 valid with 2-beat packets, rr pointer=0 -> req1 granted repeatedly. req_ready_o[0] stays 0.
- MAX_OUTSTANDING=4, res_valid_i held 0, req0 sends 5 single-beat jobs -> 4 accepted, outstanding_o=4, 5th stalls in IDLE. Return one 1-beat result -> pop; 5th granted the following cycle.
- Jobs from req1 then req0; matrix returns 2-beat result A then 1-beat result B -> A appears on rsp slice 1 only, B on slice 0 only. rsp_ready_i[1]=0 backpressures res_ready_o during A.
- Pulse rst_i mid-packet (beat 2 of 4) -> all valid/ready outputs 0 asynchronously, outstanding_o=0. After release, next grant starts from requester 0.
- Same-cycle push and pop with count=2 -> count stays 2. Head advances to the correct next ID.

Source files
------------

// File: rtl/ymp_alu_matrix_stream_sched_if.sv
// Stream bundle between requesters, the scheduler and the shared ALU matrix.
// The slave modport is the scheduler's view; master is the environment's view.
interface ymp_alu_matrix_stream_sched_if #(
    parameter int unsigned AXI_DATA_W = 32,
    parameter int unsigned N_REQ      = 2
);
    logic [N_REQ*AXI_DATA_W-1:0] req_data_i;
    logic [N_REQ-1:0]            req_valid_i;
    logic [N_REQ-1:0]            req_last_i;
    logic [N_REQ-1:0]            req_ready_o;
    logic [AXI_DATA_W-1:0]       mtx_data_o;
    logic                        mtx_valid_o;
    logic                        mtx_last_o;
    logic                        mtx_ready_i;
    logic [AXI_DATA_W-1:0]       res_data_i;
    logic                        res_valid_i;
    logic                        res_last_i;
    logic                        res_ready_o;
    logic [N_REQ*AXI_DATA_W-1:0] rsp_data_o;
    logic [N_REQ-1:0]            rsp_valid_o;
    logic [N_REQ-1:0]            rsp_last_o;
    logic [N_REQ-1:0]            rsp_ready_i;

    modport slave (
        input  req_data_i, req_valid_i, req_last_i, mtx_ready_i,
        input  res_data_i, res_valid_i, res_last_i, rsp_ready_i,
        output req_ready_o, mtx_data_o, mtx_valid_o, mtx_last_o,
        output res_ready_o, rsp_data_o, rsp_valid_o, rsp_last_o
    );

    modport master (
        output req_data_i, req_valid_i, req_last_i, mtx_ready_i,
        output res_data_i, res_valid_i, res_last_i, rsp_ready_i,
        input  req_ready_o, mtx_data_o, mtx_valid_o, mtx_last_o,
        input  res_ready_o, rsp_data_o, rsp_valid_o, rsp_last_o
    );
endinterface

// File: rtl/ymp_alu_matrix_stream_sched.sv
// Packet-granular round-robin sharing of one ALU matrix stream input; results
// are steered back to the issuing requester via an in-order ID FIFO.
module ymp_alu_matrix_stream_sched #(
    parameter int unsigned AXI_DATA_W      = 32,
    parameter int unsigned N_REQ           = 2,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    ymp_alu_matrix_stream_sched_if.slave       bus,
    output logic                               busy_o,
    output logic [$clog2(MAX_OUTSTANDING):0]   outstanding_o
);
    localparam int unsigned GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned PW = $clog2(MAX_OUTSTANDING);
    localparam int unsigned CW = PW + 1;

    typedef enum logic {S_IDLE, S_GRANT} state_e;

    state_e          state_q, state_d;
    logic [GW-1:0]   grant_q, grant_d;
    logic [GW-1:0]   rr_q, rr_d;
    logic [GW-1:0]   fifo_q [MAX_OUTSTANDING];
    logic [GW-1:0]   fifo_d [MAX_OUTSTANDING];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;

    logic            fifo_full, fifo_empty;
    logic            push, pop, res_ready;
    logic            found_hi, found_lo;
    logic [GW-1:0]   pick, pick_lo, head;

    assign fifo_full  = (count_q == CW'(MAX_OUTSTANDING));
    assign fifo_empty = (count_q == '0);

    // First valid requester at or after the rr pointer, wrapping to the lowest.
    always_comb begin
        pick     = '0;
        pick_lo  = '0;
        found_hi = 1'b0;
        found_lo = 1'b0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (bus.req_valid_i[k]) begin
                if (!found_lo) begin
                    pick_lo  = GW'(k);
                    found_lo = 1'b1;
                end
                if (!found_hi && (GW'(k) >= rr_q)) begin
                    pick     = GW'(k);
                    found_hi = 1'b1;
                end
            end
        end
        if (!found_hi) begin
            pick = pick_lo;
        end
    end

    // Grant FSM: the granted requester is passed straight through to the matrix.
    always_comb begin
        state_d         = state_q;
        grant_d         = grant_q;
        rr_d            = rr_q;
        push            = 1'b0;
        bus.mtx_data_o  = '0;
        bus.mtx_valid_o = 1'b0;
        bus.mtx_last_o  = 1'b0;
        bus.req_ready_o = '0;
        case (state_q)
            S_IDLE: begin
                if (found_lo && !fifo_full) begin
                    grant_d = pick;
                    push    = 1'b1;
                    state_d = S_GRANT;
                end
            end
            S_GRANT: begin
                for (int unsigned k = 0; k < N_REQ; k++) begin
                    if (GW'(k) == grant_q) begin
                        bus.mtx_data_o     = bus.req_data_i[k*AXI_DATA_W +: AXI_DATA_W];
                        bus.mtx_valid_o    = bus.req_valid_i[k];
                        bus.mtx_last_o     = bus.req_last_i[k];
                        bus.req_ready_o[k] = bus.mtx_ready_i;
                        if (bus.req_valid_i[k] && bus.mtx_ready_i && bus.req_last_i[k]) begin
                            state_d = S_IDLE;
                            rr_d    = (k == N_REQ - 1) ? '0 : GW'(k + 1);
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Result steering towards the requester at the FIFO head.
    always_comb begin
        head            = fifo_q[rd_ptr_q];
        res_ready       = 1'b0;
        bus.rsp_valid_o = '0;
        bus.rsp_last_o  = '0;
        if (!fifo_empty) begin
            for (int unsigned k = 0; k < N_REQ; k++) begin
                if (GW'(k) == head) begin
                    bus.rsp_valid_o[k] = bus.res_valid_i;
                    bus.rsp_last_o[k]  = bus.res_last_i;
                    res_ready          = bus.rsp_ready_i[k];
                end
            end
        end
        pop = bus.res_valid_i && res_ready && bus.res_last_i;
    end

    assign bus.res_ready_o = res_ready;
    assign bus.rsp_data_o  = {N_REQ{bus.res_data_i}};

    // ID FIFO next state; a same-cycle push and pop leaves the count unchanged.
    always_comb begin
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            fifo_d[wr_ptr_q] = grant_d;
            wr_ptr_d         = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            grant_q  <= '0;
            rr_q     <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_q     <= rr_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            fifo_q   <= fifo_d;
        end
    end

    assign busy_o        = (state_q == S_GRANT) || !fifo_empty;
    assign outstanding_o = count_q;

endmodule

// File: tb/tb_ymp_alu_matrix_stream_sched.sv
// Directed scenarios plus a randomized run against a packet-level model of the
// round-robin scheduler and in-order result return.
module tb_ymp_alu_matrix_stream_sched;
    localparam int unsigned W  = 32;
    localparam int unsigned N  = 2;
    localparam int unsigned MO = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       busy;
    logic [2:0] outstanding;
    int         tests = 0;
    int         fails = 0;

    always #5 clk = ~clk;

    ymp_alu_matrix_stream_sched_if #(.AXI_DATA_W(W), .N_REQ(N)) bus ();

    ymp_alu_matrix_stream_sched #(.AXI_DATA_W(W), .N_REQ(N), .MAX_OUTSTANDING(MO)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .bus          (bus.slave),
        .busy_o       (busy),
        .outstanding_o(outstanding)
    );

    typedef struct {
        logic [W-1:0] d;
        bit           l;
        int           dest;
    } res_t;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.req_data_i  = '0;
        bus.req_valid_i = '0;
        bus.req_last_i  = '0;
        bus.mtx_ready_i = 1'b0;
        bus.res_data_i  = '0;
        bus.res_valid_i = 1'b0;
        bus.res_last_i  = 1'b0;
        bus.rsp_ready_i = '0;
    endtask

    function automatic logic [W-1:0] beat_val(input int k, input int p, input int b);
        return 32'hA000_0000 | W'(k << 8) | W'(p << 4) | W'(b);
    endfunction

    // Drive one packet from requester k alone; grant must follow one idle cycle.
    task automatic send_pkt(input int k, input int n, input logic [W-1:0] base);
        int b = 0;
        int t = 0;
        while (b < n && t < 20) begin
            bus.req_valid_i = '0;
            bus.req_last_i  = '0;
            bus.req_valid_i[k] = 1'b1;
            bus.req_last_i[k]  = (b == n - 1);
            bus.req_data_i[k*W +: W] = base + W'(b);
            bus.mtx_ready_i = 1'b1;
            settle();
            chk("send_other_ready", 64'(bus.req_ready_o & ~(N'(1) << k)), 64'(0));
            if (bus.req_ready_o[k]) begin
                if (b == 0) chk("send_grant_lat", 64'(t), 64'(1));
                chk("send_data", 64'(bus.mtx_data_o), 64'(base + W'(b)));
                chk("send_last", 64'(bus.mtx_last_o), 64'(b == n - 1));
                b++;
            end
            t++;
            cyc();
        end
        if (b < n) chk("send_timeout_beats", 64'(b), 64'(n));
        bus.req_valid_i = '0;
        bus.req_last_i  = '0;
        bus.mtx_ready_i = 1'b0;
    endtask

    // Return a single-beat result that must be steered to requester dest.
    task automatic ret1(input int dest);
        logic [W-1:0] d = W'($urandom);
        bus.res_valid_i = 1'b1;
        bus.res_data_i  = d;
        bus.res_last_i  = 1'b1;
        bus.rsp_ready_i = '1;
        settle();
        chk("ret_valid", 64'(bus.rsp_valid_o), 64'(N'(1) << dest));
        chk("ret_last", 64'(bus.rsp_last_o), 64'(N'(1) << dest));
        chk("ret_data", 64'(bus.rsp_data_o[dest*W +: W]), 64'(d));
        chk("ret_ready", 64'(bus.res_ready_o), 64'(1));
        cyc();
        bus.res_valid_i = 1'b0;
        bus.res_last_i  = 1'b0;
        bus.rsp_ready_i = '0;
    endtask

    logic [W-1:0] rq_d [N][$];
    bit           rq_l [N][$];
    int           plen [N][$];
    logic [W-1:0] xm_d [$];
    bit           xm_l [$];
    int           xsrc [$];
    res_t         res_q [$];

    initial begin
        int order [4] = '{0, 1, 0, 1};
        int pk [N];
        int bt [N];
        int pidx [N];
        int bidx [N];
        int npk, last_end, e, p, left, kk, nb, s;
        bit found, res_drv;
        logic [N-1:0] hs;
        res_t r, rn;

        // Reset holds every valid/ready output low even with active inputs.
        rst = 1'b1;
        idle_inputs();
        bus.req_valid_i = '1;
        bus.req_last_i  = '1;
        bus.mtx_ready_i = 1'b1;
        bus.res_valid_i = 1'b1;
        bus.res_last_i  = 1'b1;
        bus.rsp_ready_i = '1;
        #2;
        chk("rst_mtx_valid", 64'(bus.mtx_valid_o), 64'(0));
        chk("rst_req_ready", 64'(bus.req_ready_o), 64'(0));
        chk("rst_rsp_valid", 64'(bus.rsp_valid_o), 64'(0));
        chk("rst_res_ready", 64'(bus.res_ready_o), 64'(0));
        cyc();
        cyc();
        rst = 1'b0;
        idle_inputs();
        settle();
        chk("rst_outstanding", 64'(outstanding), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        cyc();

        // Two requesters with 3-beat packets: grants alternate with one idle cycle.
        for (int k = 0; k < N; k++) begin
            pk[k] = 0;
            bt[k] = 0;
        end
        npk = 0;
        last_end = 0;
        for (int g = 0; g < 40 && npk < 4; g++) begin
            for (int k = 0; k < N; k++) begin
                bus.req_valid_i[k] = (pk[k] < 2);
                bus.req_last_i[k]  = (bt[k] == 2);
                bus.req_data_i[k*W +: W] = beat_val(k, pk[k], bt[k]);
            end
            bus.mtx_ready_i = 1'b1;
            settle();
            if (bus.mtx_valid_o) begin
                e = order[npk];
                chk("alt_ready", 64'(bus.req_ready_o), 64'(N'(1) << e));
                chk("alt_data", 64'(bus.mtx_data_o), 64'(beat_val(e, pk[e], bt[e])));
                chk("alt_last", 64'(bus.mtx_last_o), 64'(bt[e] == 2));
                if (bt[e] == 0 && npk > 0) chk("alt_gap", 64'(g - last_end), 64'(2));
                if (bt[e] == 2) begin
                    last_end = g;
                    pk[e]++;
                    bt[e] = 0;
                    npk++;
                end else begin
                    bt[e]++;
                end
            end
            cyc();
        end
        chk("alt_packets", 64'(npk), 64'(4));
        idle_inputs();
        chk("alt_outstanding", 64'(outstanding), 64'(4));
        chk("alt_busy", 64'(busy), 64'(1));
        ret1(0);
        ret1(1);
        ret1(0);
        ret1(1);
        chk("alt_drained", 64'(outstanding), 64'(0));

        // Only requester 1 active: it is granted repeatedly.
        send_pkt(1, 2, 32'h3100_0000);
        send_pkt(1, 2, 32'h3100_0010);
        ret1(1);
        ret1(1);

        // FIFO full: fifth job stalls until a pop, then grants one cycle later.
        for (int i = 0; i < 4; i++) send_pkt(0, 1, W'(32'h4000 + i));
        chk("full_count", 64'(outstanding), 64'(4));
        chk("full_busy", 64'(busy), 64'(1));
        bus.req_valid_i = N'(1);
        bus.req_last_i  = N'(1);
        bus.req_data_i[0 +: W] = 32'h4004;
        bus.mtx_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("full_stall", 64'(bus.mtx_valid_o), 64'(0));
            chk("full_no_ready", 64'(bus.req_ready_o), 64'(0));
            cyc();
        end
        bus.res_valid_i = 1'b1;
        bus.res_last_i  = 1'b1;
        bus.rsp_ready_i = '1;
        settle();
        chk("full_pop_valid", 64'(bus.rsp_valid_o), 64'(1));
        chk("full_pop_no_grant", 64'(bus.mtx_valid_o), 64'(0));
        cyc();
        bus.res_valid_i = 1'b0;
        bus.res_last_i  = 1'b0;
        settle();
        chk("post_pop_count", 64'(outstanding), 64'(3));
        chk("post_pop_idle", 64'(bus.mtx_valid_o), 64'(0));
        cyc();
        settle();
        chk("fifth_grant", 64'(bus.req_ready_o), 64'(1));
        chk("fifth_data", 64'(bus.mtx_data_o), 64'(32'h4004));
        cyc();
        idle_inputs();
        chk("refill_count", 64'(outstanding), 64'(4));
        for (int i = 0; i < 4; i++) ret1(0);

        // Results routed by job order; slice 1 backpressures the matrix output.
        send_pkt(1, 1, 32'h5100);
        send_pkt(0, 1, 32'h5000);
        chk("route_count", 64'(outstanding), 64'(2));
        bus.res_valid_i = 1'b1;
        bus.res_data_i  = 32'hAAAA_0000;
        bus.res_last_i  = 1'b0;
        bus.rsp_ready_i = N'(1);
        settle();
        chk("bp_valid", 64'(bus.rsp_valid_o), 64'(2));
        chk("bp_res_ready", 64'(bus.res_ready_o), 64'(0));
        chk("bp_last", 64'(bus.rsp_last_o), 64'(0));
        cyc();
        bus.rsp_ready_i = N'(2);
        settle();
        chk("a0_res_ready", 64'(bus.res_ready_o), 64'(1));
        chk("a0_data", 64'(bus.rsp_data_o[W +: W]), 64'(32'hAAAA_0000));
        chk("a0_bcast", 64'(bus.rsp_data_o[0 +: W]), 64'(32'hAAAA_0000));
        cyc();
        bus.res_data_i = 32'hAAAA_0001;
        bus.res_last_i = 1'b1;
        settle();
        chk("a1_valid", 64'(bus.rsp_valid_o), 64'(2));
        chk("a1_last", 64'(bus.rsp_last_o), 64'(2));
        cyc();
        idle_inputs();
        chk("a_popped", 64'(outstanding), 64'(1));
        ret1(0);

        // Same-cycle push and pop at count 2.
        send_pkt(0, 1, 32'h6000);
        send_pkt(1, 1, 32'h6100);
        chk("pp_pre_count", 64'(outstanding), 64'(2));
        bus.req_valid_i = N'(1);
        bus.req_last_i  = N'(1);
        bus.req_data_i[0 +: W] = 32'h6001;
        bus.mtx_ready_i = 1'b1;
        bus.res_valid_i = 1'b1;
        bus.res_last_i  = 1'b1;
        bus.rsp_ready_i = '1;
        settle();
        chk("pp_head0", 64'(bus.rsp_valid_o), 64'(1));
        chk("pp_res_ready", 64'(bus.res_ready_o), 64'(1));
        chk("pp_idle", 64'(bus.mtx_valid_o), 64'(0));
        cyc();
        bus.res_last_i  = 1'b0;
        bus.rsp_ready_i = '0;
        settle();
        chk("pp_count", 64'(outstanding), 64'(2));
        chk("pp_head1", 64'(bus.rsp_valid_o), 64'(2));
        chk("pp_grant0", 64'(bus.req_ready_o), 64'(1));
        cyc();
        idle_inputs();
        ret1(1);
        ret1(0);
        chk("pp_drained", 64'(outstanding), 64'(0));

        // Reset asserted mid-packet (req1, beat 2 of 4) with rr pointer at 1.
        bus.req_valid_i = N'(2);
        bus.mtx_ready_i = 1'b1;
        for (int b = 0; b < 3; b++) begin
            bus.req_data_i[W +: W] = beat_val(1, 7, b);
            cyc();
        end
        bus.res_valid_i = 1'b1;
        #1;
        chk("rst_pre_mtx_valid", 64'(bus.mtx_valid_o), 64'(1));
        chk("rst_pre_rsp_valid", 64'(bus.rsp_valid_o), 64'(2));
        rst = 1'b1;
        #1;
        chk("arst_mtx_valid", 64'(bus.mtx_valid_o), 64'(0));
        chk("arst_req_ready", 64'(bus.req_ready_o), 64'(0));
        chk("arst_rsp_valid", 64'(bus.rsp_valid_o), 64'(0));
        chk("arst_outstanding", 64'(outstanding), 64'(0));
        chk("arst_busy", 64'(busy), 64'(0));
        cyc();
        cyc();
        rst = 1'b0;
        idle_inputs();
        bus.req_valid_i = '1;
        bus.req_last_i  = '1;
        bus.req_data_i  = {32'h7100, 32'h7000};
        bus.mtx_ready_i = 1'b1;
        settle();
        chk("post_rst_idle", 64'(bus.req_ready_o), 64'(0));
        cyc();
        settle();
        chk("post_rst_grant0", 64'(bus.req_ready_o), 64'(1));
        chk("post_rst_data", 64'(bus.mtx_data_o), 64'(32'h7000));
        cyc();
        idle_inputs();
        ret1(0);

        // Randomized run: packet order and result routing from the model.
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        left = 0;
        for (int k = 0; k < N; k++) begin
            int np = int'($urandom_range(3, 6));
            for (int q = 0; q < np; q++) begin
                int n = int'($urandom_range(1, 4));
                plen[k].push_back(n);
                for (int b = 0; b < n; b++) begin
                    rq_d[k].push_back(W'($urandom));
                    rq_l[k].push_back(b == n - 1);
                end
            end
            left += np;
            pidx[k] = 0;
            bidx[k] = 0;
        end
        p = 0;
        while (left > 0) begin
            found = 1'b0;
            kk = 0;
            for (int d = 0; d < N; d++) begin
                if (!found && pidx[(p + d) % N] < plen[(p + d) % N].size()) begin
                    kk = (p + d) % N;
                    found = 1'b1;
                end
            end
            for (int b = 0; b < plen[kk][pidx[kk]]; b++) begin
                xm_d.push_back(rq_d[kk][bidx[kk] + b]);
                xm_l.push_back(rq_l[kk][bidx[kk] + b]);
            end
            bidx[kk] += plen[kk][pidx[kk]];
            pidx[kk]++;
            xsrc.push_back(kk);
            p = (kk + 1) % N;
            left--;
        end

        for (int c = 0; c < 4000 && (xm_d.size() > 0 || res_q.size() > 0); c++) begin
            for (int k = 0; k < N; k++) begin
                bus.req_valid_i[k] = (rq_d[k].size() > 0);
                bus.req_data_i[k*W +: W] = (rq_d[k].size() > 0) ? rq_d[k][0] : '0;
                bus.req_last_i[k] = (rq_l[k].size() > 0) ? rq_l[k][0] : 1'b0;
                bus.rsp_ready_i[k] = ($urandom_range(0, 1) == 1);
            end
            bus.mtx_ready_i = ($urandom_range(0, 3) != 0);
            res_drv = (res_q.size() > 0) && ($urandom_range(0, 3) != 0);
            if (res_drv) begin
                r = res_q[0];
                bus.res_valid_i = 1'b1;
                bus.res_data_i  = r.d;
                bus.res_last_i  = r.l;
            end else begin
                bus.res_valid_i = 1'b0;
                bus.res_last_i  = 1'b0;
            end
            settle();
            if (bus.mtx_valid_o && bus.mtx_ready_i) begin
                hs = bus.req_ready_o & bus.req_valid_i;
                chk("rnd_one_src", 64'($countones(hs)), 64'(1));
                chk("rnd_beat_expected", 64'(xm_d.size() > 0), 64'(1));
                for (int k = 0; k < N; k++) begin
                    if (hs[k] && rq_d[k].size() > 0) begin
                        void'(rq_d[k].pop_front());
                        void'(rq_l[k].pop_front());
                    end
                end
                if (xm_d.size() > 0) begin
                    chk("rnd_mtx_data", 64'(bus.mtx_data_o), 64'(xm_d[0]));
                    chk("rnd_mtx_last", 64'(bus.mtx_last_o), 64'(xm_l[0]));
                    if (xm_l[0]) begin
                        s = xsrc.pop_front();
                        nb = int'($urandom_range(1, 3));
                        for (int b = 0; b < nb; b++) begin
                            rn.d = W'($urandom);
                            rn.l = (b == nb - 1);
                            rn.dest = s;
                            res_q.push_back(rn);
                        end
                    end
                    void'(xm_d.pop_front());
                    void'(xm_l.pop_front());
                end
            end
            if (res_drv) begin
                chk("rnd_rsp_valid", 64'(bus.rsp_valid_o), 64'(N'(1) << r.dest));
                chk("rnd_res_ready", 64'(bus.res_ready_o), 64'(bus.rsp_ready_i[r.dest]));
                if (bus.res_ready_o) begin
                    chk("rnd_rsp_data", 64'(bus.rsp_data_o[r.dest*W +: W]), 64'(r.d));
                    chk("rnd_rsp_last", 64'(bus.rsp_last_o), 64'(r.l ? (N'(1) << r.dest) : N'(0)));
                    void'(res_q.pop_front());
                end
            end
            chk("rnd_occ_bound", 64'(outstanding <= 3'(MO)), 64'(1));
            cyc();
        end
        idle_inputs();
        chk("rnd_mtx_left", 64'(xm_d.size()), 64'(0));
        chk("rnd_res_left", 64'(res_q.size()), 64'(0));
        settle();
        chk("rnd_end_outstanding", 64'(outstanding), 64'(0));
        chk("rnd_end_busy", 64'(busy), 64'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
